// File: rtl/burst_xfer_arbiter.sv
// burst_xfer_arbiter: two-requester round-robin sequencer that turns whole
// burst commands into beat-by-beat burst_en/addr/wren/rden traffic for the
// burst memory, and returns read data to the requester that owns the burst.
module burst_xfer_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8,
  parameter int RD_LAT     = 1,
  parameter int LW         = $clog2(BURST_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_wr,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*LW-1:0]         req_len,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              wdata_req,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rdata_valid,
  output logic [1:0]              done,
  output logic                    len_err,
  output logic                    burst_en,
  output logic [ADDR_WIDTH-1:0]   addr_top,
  output logic                    wren,
  output logic                    rden,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] LEN_MAX = LW'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_q;
  logic                    last_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           cnt_q;
  logic [LW-1:0]           ret_q;
  logic                    len_err_q;
  logic [RD_LAT:0]         rd_sr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  // Arbitration: with both requesting, the one that was not granted last wins.
  logic                    gnt_sel;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LW-1:0]           sel_len;
  logic                    len_bad;
  logic [LW-1:0]           len_clamped;
  logic                    take;

  assign gnt_sel     = req_valid[1] & (~req_valid[0] | ~last_q);
  assign sel_wr      = gnt_sel ? req_wr[1] : req_wr[0];
  assign sel_addr    = gnt_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_len     = gnt_sel ? req_len[2*LW-1:LW] : req_len[LW-1:0];
  assign len_bad     = (sel_len == '0) || (sel_len > LEN_MAX);
  assign len_clamped = (sel_len == '0) ? LEN_ONE : ((sel_len > LEN_MAX) ? LEN_MAX : sel_len);
  // rst gate keeps req_ready low while reset is held even if requests are pending.
  assign take        = (state_q == S_IDLE) && (|req_valid) && !rst;

  // Read-return tracking: tap k is high k cycles after a rden beat.
  logic [RD_LAT+1:0]       rd_tap;
  logic                    ret_fire;
  logic                    beat_last;
  logic                    ret_last;

  assign rd_tap    = {rd_sr_q, rden};
  assign ret_fire  = rd_tap[RD_LAT+1];
  assign beat_last = (cnt_q == len_q - LEN_ONE);
  assign ret_last  = (ret_q == len_q - LEN_ONE);

  assign rdata_valid = ret_fire ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata       = rdata_q;
  assign len_err     = len_err_q;

  // Control state, counters, read-return pipeline; all cleared by async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      wr_q      <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      ret_q     <= '0;
      len_err_q <= 1'b0;
      rd_sr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= gnt_sel;
        last_q  <= gnt_sel;
        wr_q    <= sel_wr;
        len_q   <= len_clamped;
        cnt_q   <= '0;
        ret_q   <= '0;
        if (len_bad) begin
          len_err_q <= 1'b1;
        end
      end else if (state_q == S_XFER) begin
        cnt_q <= cnt_q + LEN_ONE;
      end
      if (ret_fire) begin
        ret_q <= ret_q + LEN_ONE;
      end
      rd_sr_q <= rd_tap[RD_LAT:0];
      if (rd_tap[RD_LAT]) begin
        rdata_q <= mem_rd_data;
      end
    end
  end

  // Start address is only meaningful while in XFER, so it needs no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q <= sel_addr;
    end
  end

  // Next-state and beat outputs; memory interface is quiet outside XFER.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    wdata_req = 2'b00;
    done      = 2'b00;
    burst_en  = 1'b0;
    wren      = 1'b0;
    rden      = 1'b0;
    addr_top  = '0;
    wr_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          req_ready[gnt_sel] = 1'b1;
          state_d            = S_XFER;
        end
      end
      S_XFER: begin
        burst_en = (len_q > LEN_ONE);
        wren     = wr_q;
        rden     = ~wr_q;
        addr_top = addr_q;
        if (wr_q) begin
          wdata_req[grant_q] = 1'b1;
          wr_data            = grant_q ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
        end
        if (beat_last) begin
          if (wr_q) begin
            done[grant_q] = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (ret_fire && ret_last) begin
          done[grant_q] = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_burst_xfer_arbiter.sv
// Testbench for burst_xfer_arbiter: a small burst memory model, two
// requesters, and a scoreboard fed at grant time and drained by a monitor.
module tb_burst_xfer_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int BL = 8;
  localparam int RL = 1;
  localparam int LW = $clog2(BL + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_wr, req_ready, wdata_req, rdata_valid, done;
  logic [2*AW-1:0] req_addr;
  logic [2*LW-1:0] req_len;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0]   rdata, wr_data, mem_rd_data;
  logic            len_err, burst_en, wren, rden;
  logic [AW-1:0]   addr_top;

  // Requester-side state
  logic          rv [2];
  logic          rw [2];
  logic [AW-1:0] ra [2];
  logic [LW-1:0] rl [2];
  logic [DW-1:0] wdat [2][8];
  logic [2:0]    widx [2];

  assign req_valid = {rv[1], rv[0]};
  assign req_wr    = {rw[1], rw[0]};
  assign req_addr  = {ra[1], ra[0]};
  assign req_len   = {rl[1], rl[0]};
  assign wdata     = {wdat[1][widx[1]], wdat[0][widx[0]]};

  burst_xfer_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .RD_LAT(RL), .LW(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .wdata(wdata), .wdata_req(wdata_req),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .len_err(len_err),
    .burst_en(burst_en), .addr_top(addr_top), .wren(wren), .rden(rden),
    .wr_data(wr_data), .mem_rd_data(mem_rd_data)
  );

  // Requester write-data pointers advance on each consumed beat.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) widx[i] <= '0;
      else if (req_ready[i]) widx[i] <= '0;
      else if (wdata_req[i]) widx[i] <= widx[i] + 3'd1;
    end
  end

  // Burst memory model: holds the start address, auto-increments per beat.
  logic [DW-1:0] mem [256];
  logic [AW-1:0] midx, maddr;
  assign maddr = addr_top + midx;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i) ^ 8'h5A;
      midx        <= '0;
      mem_rd_data <= '0;
    end else begin
      if (wren) mem[maddr] <= wr_data;
      if (rden) mem_rd_data <= mem[maddr];
      midx <= (wren || rden) ? midx + 1'b1 : '0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct packed {
    logic          own;
    logic          wr;
    logic [AW-1:0] addr;
    logic          be;
    logic [DW-1:0] data;
  } beat_t;
  typedef struct packed {
    logic          own;
    logic [DW-1:0] data;
  } rd_t;

  beat_t         bq[$];
  rd_t           rq[$];
  int            tq[$];
  logic          dq[$];
  logic          gseq[$];
  logic [DW-1:0] rx1[$];
  logic [DW-1:0] shadow [256];
  logic          last_g;
  logic          exp_lerr;
  int            be_cnt, beat_cnt, run;
  int            nchk = 0;
  int            nerr = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [1:0] oh(logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    bq.delete(); rq.delete(); tq.delete(); dq.delete();
    last_g   = 1'b1;
    exp_lerr = 1'b0;
    run      = 0;
    for (int i = 0; i < 256; i++) shadow[i] = DW'(i) ^ 8'h5A;
  endtask

  task automatic monitor();
    logic          g;
    logic [LW-1:0] l;
    int            eff;
    logic [AW-1:0] a;
    beat_t         e;
    rd_t           r;
    int            t;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else begin
        if (req_ready != 2'b00) begin
          g = (req_valid == 2'b11) ? ~last_g : req_valid[1];
          chk("grant", {dq.size() != 0, req_ready}, {1'b0, oh(g)});
          last_g = g;
          gseq.push_back(g);
          l   = rl[g];
          eff = (l == 0) ? 1 : ((int'(l) > BL) ? BL : int'(l));
          if (l == 0 || int'(l) > BL) exp_lerr = 1'b1;
          for (int k = 0; k < eff; k++) begin
            a = ra[g] + AW'(k);
            if (rw[g]) begin
              shadow[a] = wdat[g][k];
              bq.push_back('{g, 1'b1, ra[g], eff > 1, wdat[g][k]});
            end else begin
              bq.push_back('{g, 1'b0, ra[g], eff > 1, '0});
              rq.push_back('{g, shadow[a]});
            end
          end
          dq.push_back(g);
        end
        if (wren || rden || burst_en || wdata_req != 2'b00) begin
          beat_cnt++;
          if (bq.size() == 0) begin
            chk("beat_unexpected", 1, 0);
          end else begin
            e = bq.pop_front();
            chk("beat", {wren, rden, burst_en, addr_top, wdata_req, wren ? wr_data : 8'h00},
                        {e.wr, ~e.wr, e.be, e.addr, e.wr ? oh(e.own) : 2'b00, e.data});
          end
          if (rden) tq.push_back(cyc + RL + 1);
        end
        if (burst_en) begin
          be_cnt++;
          run++;
        end else if (run > 0) begin
          chk("burst_en_run_le_max", run <= BL, 1);
          run = 0;
        end
        if (rdata_valid != 2'b00) begin
          if (rq.size() == 0 || tq.size() == 0) begin
            chk("rdata_unexpected", 1, 0);
          end else begin
            r = rq.pop_front();
            t = tq.pop_front();
            chk("rdata", {rdata_valid, rdata}, {oh(r.own), r.data});
            chk("rd_latency", cyc, t);
          end
          if (rdata_valid[1]) rx1.push_back(rdata);
        end
        if (done != 2'b00) begin
          if (dq.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            g = dq.pop_front();
            chk("done", {done, bq.size() == 0, rq.size() == 0, len_err},
                        {oh(g), 1'b1, 1'b1, exp_lerr});
          end
        end
      end
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int to;
    @(posedge clk);
    #1;
    rw[i] = w; ra[i] = a; rl[i] = l; rv[i] = 1'b1;
    to = 0;
    @(negedge clk);
    while (!req_ready[i] && to < 300) begin
      to++;
      @(negedge clk);
    end
    if (to >= 300) chk("req_ready_timeout", 1, 0);
    @(posedge clk);
    #1;
    rv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int to;
    to = 0;
    @(negedge clk);
    while (!done[i] && to < 300) begin
      to++;
      @(negedge clk);
    end
    if (to >= 300) chk("done_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int to;
    to = 0;
    while (dq.size() != 0 && to < 300) begin
      to++;
      @(negedge clk);
    end
    if (to >= 300) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int i);
    logic          w;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int            sel;
    for (int n = 0; n < 12; n++) begin
      w   = 1'($urandom_range(0, 1));
      a   = AW'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) l = '0;
      else if (sel == 1) l = LW'($urandom_range(9, 15));
      else l = LW'($urandom_range(1, 8));
      for (int k = 0; k < 8; k++) wdat[i][k] = DW'($urandom);
      issue(i, w, a, l);
      wait_done(i);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int to;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rl[i] = '0;
      for (int k = 0; k < 8; k++) wdat[i][k] = '0;
    end
    model_reset();
    be_cnt = 0; beat_cnt = 0;
    fork
      monitor();
    join_none

    // Reset state with both requesters already pending
    repeat (3) @(posedge clk);
    #1;
    rw[0] = 1'b1; ra[0] = 8'd30; rl[0] = LW'(2); wdat[0][0] = 8'hA0; wdat[0][1] = 8'hA1;
    rw[1] = 1'b0; ra[1] = 8'd30; rl[1] = LW'(2);
    rv[0] = 1'b1; rv[1] = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {req_ready, wdata_req, rdata_valid, done, len_err, burst_en, wren, rden,
                          addr_top, wr_data, rdata}, 64'd0);

    // Test 3: both held from reset -> grants alternate starting with requester 0
    @(posedge clk);
    #1;
    rst = 1'b0;
    to = 0;
    while (gseq.size() < 4 && to < 200) begin
      to++;
      @(negedge clk);
    end
    if (to >= 200) chk("t3_timeout", 1, 0);
    @(posedge clk);
    #1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    wait_idle();
    chk("t3_grant_order", {gseq[0], gseq[1], gseq[2], gseq[3]}, 4'b0101);

    // Test 1: write 17,18,19,1A at 7
    wdat[0][0] = 8'h17; wdat[0][1] = 8'h18; wdat[0][2] = 8'h19; wdat[0][3] = 8'h1A;
    be_cnt = 0; beat_cnt = 0;
    issue(0, 1'b1, 8'd7, LW'(4));
    wait_done(0);
    chk("t1_burst_en_cycles", be_cnt, 4);
    chk("t1_beats", beat_cnt, 4);

    // Test 2: requester 1 reads them back
    rx1.delete();
    issue(1, 1'b0, 8'd7, LW'(4));
    wait_done(1);
    chk("t2_rdata", {8'(rx1.size()), rx1[0], rx1[1], rx1[2], rx1[3]}, 40'h04_17_18_19_1A);

    // Test 4: single beat, burst_en stays low
    wdat[0][0] = 8'h3C;
    be_cnt = 0; beat_cnt = 0;
    issue(0, 1'b1, 8'd12, LW'(1));
    wait_done(0);
    chk("t4_burst_en_cycles", be_cnt, 0);
    chk("t4_beats", beat_cnt, 1);
    chk("t4_len_err_clear", len_err, 0);

    // Test 5: oversize length clamps to BURST_LEN, zero length to one beat
    for (int k = 0; k < 8; k++) wdat[0][k] = DW'(8'h40 + k);
    be_cnt = 0; beat_cnt = 0;
    issue(0, 1'b1, 8'd64, LW'(12));
    wait_done(0);
    chk("t5_burst_en_cycles", be_cnt, 8);
    chk("t5_beats", beat_cnt, 8);
    chk("t5_len_err", len_err, 1);
    be_cnt = 0; beat_cnt = 0;
    issue(0, 1'b1, 8'd80, LW'(0));
    wait_done(0);
    chk("t5_len0_burst_en", be_cnt, 0);
    chk("t5_len0_beats", beat_cnt, 1);
    chk("t5_len0_len_err", len_err, 1);

    // Randomized traffic from both requesters
    fork
      rand_req(0);
      rand_req(1);
    join
    wait_idle();

    // Test 6: async reset in beat 2 of a len-8 write
    for (int k = 0; k < 8; k++) wdat[0][k] = DW'(8'h60 + k);
    issue(0, 1'b1, 8'd100, LW'(8));
    to = 0;
    @(negedge clk);
    while (!(wdata_req[0] && widx[0] == 3'd2) && to < 50) begin
      to++;
      @(negedge clk);
    end
    if (to >= 50) chk("t6_beat2_timeout", 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {req_ready, wdata_req, rdata_valid, done, len_err, burst_en, wren, rden,
                           addr_top, wr_data, rdata}, 64'd0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_done_in_rst", done, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_done_after_rst", done, 0);
    rx1.delete();
    issue(1, 1'b0, 8'd7, LW'(2));
    wait_done(1);
    chk("t6_read_after_rst", {8'(rx1.size()), rx1[0], rx1[1]}, {8'd2, 8'h07 ^ 8'h5A, 8'h08 ^ 8'h5A});
    chk("t6_scoreboard_empty", {8'(bq.size()), 8'(rq.size()), 8'(dq.size())}, 24'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
